// File: rtl/mem_copy_if.sv
// Memory bus between the copy master and the 32x32 data memory.
interface mem_copy_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] direc;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;

  modport master (output MemRead, MemWrite, direc, WriteData, input ReadData);
  modport slave  (input MemRead, MemWrite, direc, WriteData, output ReadData);
endinterface

// File: rtl/mem_copy_master.sv
// Block copy initiator for the data memory: one read+write pair per word, ascending.
// Optional MEM_COPY_FILL_EN adds a fill mode that writes a constant word without reading.
module mem_copy_master #(
  parameter int DEPTH = 32,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LENW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   src_addr,
  input  logic [AW-1:0]   dst_addr,
  input  logic [LENW-1:0] len,
`ifdef MEM_COPY_FILL_EN
  input  logic            fill,
  input  logic [DW-1:0]   fill_data,
`endif
  output logic            busy,
  output logic            done,
  output logic            err,
  mem_copy_if.master      bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [1:0]      r_state;
  logic [AW-1:0]   r_src, r_dst, r_direc;
  logic [LENW-1:0] r_len, r_idx;
  logic [DW-1:0]   r_data;
  logic            r_err, r_fill;

  logic            w_fill_cmd;
  logic [AW:0]     w_src_end, w_dst_end;
  logic            w_rng_err, w_last;
  logic [LENW-1:0] w_nidx;

`ifdef MEM_COPY_FILL_EN
  assign w_fill_cmd = fill;
`else
  assign w_fill_cmd = 1'b0;
`endif

  // End addresses carry one extra bit so a range past the top can never wrap into range
  assign w_src_end = {1'b0, src_addr} + (AW+1)'(len);
  assign w_dst_end = {1'b0, dst_addr} + (AW+1)'(len);
  assign w_rng_err = (w_dst_end > DEPTH_W) || (!w_fill_cmd && (w_src_end > DEPTH_W));
  assign w_last    = (r_idx == r_len - 1'b1);
  assign w_nidx    = r_idx + 1'b1;

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign err           = (r_state == S_DONE) && r_err;
  assign bus.MemRead   = (r_state == S_READ);
  assign bus.MemWrite  = (r_state == S_WRITE);
  assign bus.direc     = r_direc;
  assign bus.WriteData = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_direc <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_fill  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src  <= src_addr;
            r_dst  <= dst_addr;
            r_len  <= len;
            r_idx  <= '0;
            r_err  <= 1'b0;
            r_fill <= w_fill_cmd;
`ifdef MEM_COPY_FILL_EN
            if (fill) r_data <= fill_data;
`endif
            if (len == '0) begin
              r_state <= S_DONE;
            end else if (w_rng_err) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (w_fill_cmd) begin
              r_direc <= dst_addr;
              r_state <= S_WRITE;
            end else begin
              r_direc <= src_addr;
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_data  <= bus.ReadData;
          r_direc <= r_dst + AW'(r_idx);
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_idx <= w_nidx;
          if (w_last) begin
            r_state <= S_DONE;
          end else if (r_fill) begin
            r_direc <= r_dst + AW'(w_nidx);
          end else begin
            r_direc <= r_src + AW'(w_nidx);
            r_state <= S_READ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
